fir_xifu_mac_engine: RTL and testbench

// - Parametrised multi-channel FIR compute engine behind the FIR XIFU decoder/writeback stages.
// - Stores NUM_TAPS coefficients and a circular history of NUM_TAPS samples per channel.
// - Each accepted sample triggers a sequential one-MAC-per-cycle dot product.
// - The result is scaled and handed back over a valid/ready port, where STSAM consumes it.

---
 rtl/fir_xifu_pkg.sv | 41 ++++
 rtl/fir_xifu_ring_buffer.sv | 46 ++++
 rtl/fir_xifu_mac_engine.sv | 121 ++++++++++++
 tb/tb_fir_xifu_mac_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types, default sizing and output scaling for the FIR XIFU MAC engine.
// Define FIR_XIFU_SATURATE_EN to clamp results instead of wrapping them.
package fir_xifu_pkg;

   typedef enum logic [1:0] {
      MAC_IDLE,
      MAC_RUN,
      MAC_OUT
   } fir_xifu_mac_state_t;

   localparam int FIR_NUM_TAPS     = 8;
   localparam int FIR_NUM_CHANNELS = 2;
   localparam int FIR_DATA_WIDTH   = 16;
   localparam int FIR_ACC_WIDTH    = 40;
   localparam int FIR_OUT_SHIFT    = 15;
   localparam int FIR_SCALE_W      = 64;

   // Caller keeps the low data_width bits; plain truncation gives two's-complement wrap.
   function automatic logic signed [FIR_SCALE_W-1:0] fir_xifu_scale(
      input logic signed [FIR_SCALE_W-1:0] acc,
      input int                            shift,
      input int                            data_width
   );
      logic signed [FIR_SCALE_W-1:0] y;
`ifdef FIR_XIFU_SATURATE_EN
      logic signed [FIR_SCALE_W-1:0] y_max;
      logic signed [FIR_SCALE_W-1:0] y_min;
`endif
      y = acc >>> shift;
`ifdef FIR_XIFU_SATURATE_EN
      y_max = (64'sd1 <<< (data_width - 1)) - 64'sd1;
      y_min = -y_max - 64'sd1;
      if (y > y_max) y = y_max;
      else if (y < y_min) y = y_min;
`else
      if (data_width < 1) y = '0;
`endif
      return y;
   endfunction

endpackage

// File: rtl/fir_xifu_ring_buffer.sv
// Per-channel circular store: write appends at a wrapping pointer, read is either
// absolute or counted backwards from the newest entry (READ_REL).
module fir_xifu_ring_buffer
   import fir_xifu_pkg::*;
#(
   parameter int NUM_CH   = FIR_NUM_CHANNELS,
   parameter int DEPTH    = FIR_NUM_TAPS,
   parameter int WIDTH    = FIR_DATA_WIDTH,
   parameter int CH_W     = 1,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int RST_PTR  = 0,
   parameter bit READ_REL = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic signed [WIDTH-1:0] wr_data,
   input  logic [CH_W-1:0]         rd_ch,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic signed [WIDTH-1:0] rd_data
);

   logic signed [WIDTH-1:0] mem [NUM_CH][DEPTH];
   logic [IDX_W-1:0]        ptr [NUM_CH];
   logic [IDX_W-1:0]        rd_addr;

   // NOTE: contents are reset explicitly because a cleared bank is architecturally visible.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ptr[c] <= IDX_W'(RST_PTR);
            for (int i = 0; i < DEPTH; i++) mem[c][i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ch][ptr[wr_ch]] <= wr_data;
         ptr[wr_ch]             <= ptr[wr_ch] + 1'b1;
      end
   end

   // Relative read: index 0 is the entry written most recently.
   assign rd_addr = READ_REL ? (ptr[rd_ch] - rd_idx - 1'b1) : rd_idx;
   assign rd_data = mem[rd_ch][rd_addr];

endmodule

// File: rtl/fir_xifu_mac_engine.sv
// Multi-channel FIR engine: one MAC per cycle over NUM_TAPS taps, result on valid/ready.
// Output reduction saturates when FIR_XIFU_SATURATE_EN is defined, otherwise wraps.
module fir_xifu_mac_engine
   import fir_xifu_pkg::*;
#(
   parameter int NUM_TAPS     = FIR_NUM_TAPS,
   parameter int NUM_CHANNELS = FIR_NUM_CHANNELS,
   parameter int DATA_WIDTH   = FIR_DATA_WIDTH,
   parameter int ACC_WIDTH    = FIR_ACC_WIDTH,
   parameter int OUT_SHIFT    = FIR_OUT_SHIFT,
   localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int IDX_W       = $clog2(NUM_TAPS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tap_valid_i,
   output logic                  tap_ready_o,
   input  logic [CH_W-1:0]       tap_ch_i,
   input  logic [DATA_WIDTH-1:0] tap_data_i,
   input  logic                  sample_valid_i,
   output logic                  sample_ready_o,
   input  logic [CH_W-1:0]       sample_ch_i,
   input  logic [DATA_WIDTH-1:0] sample_data_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [CH_W-1:0]       result_ch_o,
   output logic [DATA_WIDTH-1:0] result_data_o
);

   fir_xifu_mac_state_t state, state_nx;

   logic [CH_W-1:0]                ch_q;
   logic [IDX_W-1:0]               k_q;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic signed [DATA_WIDTH-1:0]   tap_rd;
   logic signed [DATA_WIDTH-1:0]   hist_rd;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic                           tap_fire;
   logic                           sample_fire;

   assign tap_fire    = tap_valid_i & tap_ready_o;
   assign sample_fire = sample_valid_i & sample_ready_o;

   fir_xifu_ring_buffer #(
      .NUM_CH(NUM_CHANNELS), .DEPTH(NUM_TAPS), .WIDTH(DATA_WIDTH),
      .CH_W(CH_W), .IDX_W(IDX_W), .RST_PTR(0), .READ_REL(1'b0)
   ) u_taps (
      .clk_i(clk_i), .rst_i(rst_i),
      .wr_en(tap_fire), .wr_ch(tap_ch_i), .wr_data(tap_data_i),
      .rd_ch(ch_q), .rd_idx(k_q), .rd_data(tap_rd)
   );

   // History pointer resets to 1 so the head (pointer - 1) starts at slot 0.
   fir_xifu_ring_buffer #(
      .NUM_CH(NUM_CHANNELS), .DEPTH(NUM_TAPS), .WIDTH(DATA_WIDTH),
      .CH_W(CH_W), .IDX_W(IDX_W), .RST_PTR(1), .READ_REL(1'b1)
   ) u_hist (
      .clk_i(clk_i), .rst_i(rst_i),
      .wr_en(sample_fire), .wr_ch(sample_ch_i), .wr_data(sample_data_i),
      .rd_ch(ch_q), .rd_idx(k_q), .rd_data(hist_rd)
   );

   assign prod = tap_rd * hist_rd;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= MAC_IDLE;
      else       state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      state_nx       = state;
      tap_ready_o    = 1'b0;
      sample_ready_o = 1'b0;
      result_valid_o = 1'b0;
      case (state)
         MAC_IDLE: begin
            tap_ready_o    = 1'b1;
            sample_ready_o = 1'b1;
            if (sample_valid_i) state_nx = MAC_RUN;
         end
         MAC_RUN: begin
            if (k_q == IDX_W'(NUM_TAPS - 1)) state_nx = MAC_OUT;
         end
         MAC_OUT: begin
            result_valid_o = 1'b1;
            if (result_ready_i) state_nx = MAC_IDLE;
         end
         default: state_nx = MAC_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ch_q  <= '0;
         k_q   <= '0;
         acc_q <= '0;
      end else begin
         case (state)
            MAC_IDLE: begin
               if (sample_fire) begin
                  ch_q  <= sample_ch_i;
                  k_q   <= '0;
                  acc_q <= '0;
               end
            end
            MAC_RUN: begin
               acc_q <= acc_q + ACC_WIDTH'(prod);
               k_q   <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result_ch_o   = ch_q;
   assign result_data_o = (state == MAC_OUT)
                        ? DATA_WIDTH'(fir_xifu_scale(FIR_SCALE_W'(acc_q), OUT_SHIFT, DATA_WIDTH))
                        : '0;

endmodule

// File: tb/tb_fir_xifu_mac_engine.sv
// Scoreboard bench: two engines (OUT_SHIFT 0 and 15) on shared buses, selected by sel.
`timescale 1ns/1ps
module tb_fir_xifu_mac_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        tap_valid, sample_valid, result_ready;
   logic        tap_ch, sample_ch;
   logic [15:0] tap_data, sample_data;
   logic        tap_ready [2];
   logic        sample_ready [2];
   logic        result_valid [2];
   logic        result_ch [2];
   logic [15:0] result_data [2];

   always #5 clk = ~clk;

   fir_xifu_mac_engine #(
      .NUM_TAPS(8), .NUM_CHANNELS(2), .DATA_WIDTH(16), .ACC_WIDTH(40), .OUT_SHIFT(0)
   ) dut0 (
      .clk_i(clk), .rst_i(rst),
      .tap_valid_i(tap_valid & ~sel), .tap_ready_o(tap_ready[0]),
      .tap_ch_i(tap_ch), .tap_data_i(tap_data),
      .sample_valid_i(sample_valid & ~sel), .sample_ready_o(sample_ready[0]),
      .sample_ch_i(sample_ch), .sample_data_i(sample_data),
      .result_valid_o(result_valid[0]), .result_ready_i(result_ready),
      .result_ch_o(result_ch[0]), .result_data_o(result_data[0])
   );

   fir_xifu_mac_engine #(
      .NUM_TAPS(8), .NUM_CHANNELS(2), .DATA_WIDTH(16), .ACC_WIDTH(40), .OUT_SHIFT(15)
   ) dut15 (
      .clk_i(clk), .rst_i(rst),
      .tap_valid_i(tap_valid & sel), .tap_ready_o(tap_ready[1]),
      .tap_ch_i(tap_ch), .tap_data_i(tap_data),
      .sample_valid_i(sample_valid & sel), .sample_ready_o(sample_ready[1]),
      .sample_ch_i(sample_ch), .sample_data_i(sample_data),
      .result_valid_o(result_valid[1]), .result_ready_i(result_ready),
      .result_ch_o(result_ch[1]), .result_data_o(result_data[1])
   );

   typedef struct {
      int          dut;
      int          ch;
      logic [15:0] data;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   // Monitor: a result is consumed on the clock edge that follows this sample point.
   initial begin : monitor
      logic prev [2];
      int   rise [2];
      exp_t e;
      prev = '{1'b0, 1'b0};
      rise = '{0, 0};
      forever begin
         @(negedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (result_valid[d] === 1'b1 && prev[d] !== 1'b1) rise[d] = cyc;
            prev[d] = result_valid[d];
            if (result_valid[d] === 1'b1 && result_ready === 1'b1) begin
               if (q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_result: dut %0d offered 0x%0h with nothing required", d, result_data[d]);
               end else begin
                  e = q.pop_front();
                  check("result_dut", 64'(d), 64'(e.dut));
                  check("result_ch", 64'(result_ch[d]), 64'(e.ch));
                  check("result_data", 64'(result_data[d]), 64'(e.data));
                  check("result_latency", 64'(rise[d] - e.acc_cyc), 64'd9);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic reset_dut(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_tap(input logic d, input logic ch, input logic [15:0] data);
      int n = 0;
      @(negedge clk);
      sel = d; tap_valid = 1'b1; tap_ch = ch; tap_data = data;
      while (tap_ready[d] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("tap_ready");
      @(negedge clk);
      tap_valid = 1'b0;
   endtask

   task automatic finish_sample(input bit push, input logic [15:0] exp_data);
      int n = 0;
      while (sample_ready[sel] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("sample_ready");
      else if (push) q.push_back('{dut: int'(sel), ch: int'(sample_ch), data: exp_data, acc_cyc: cyc});
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic send_sample(input logic d, input logic ch, input logic [15:0] data,
                              input logic [15:0] exp_data, input bit push = 1'b1);
      @(negedge clk);
      sel = d; sample_valid = 1'b1; sample_ch = ch; sample_data = data;
      finish_sample(push, exp_data);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
      if (q.size() != 0) timeout("drain");
      @(negedge clk);
   endtask

   // All taps and samples 0x7FFF: after j samples acc = j*0x7FFF^2.
   function automatic logic [15:0] sat_model(input int j);
      longint acc;
      longint y;
      acc = longint'(j) * 64'sd32767 * 64'sd32767;
      y   = acc >>> 15;
`ifdef FIR_XIFU_SATURATE_EN
      if (y > 64'sd32767) y = 64'sd32767;
`endif
      return y[15:0];
   endfunction

   initial begin : stimulus
      int n;
      sel = 1'b0; rst = 1'b0; result_ready = 1'b1;
      tap_valid = 1'b0; tap_ch = 1'b0; tap_data = '0;
      sample_valid = 1'b0; sample_ch = 1'b0; sample_data = '0;

      // Reset state
      reset_dut(2);
      for (int d = 0; d < 2; d++) begin
         check("rst_result_valid", 64'(result_valid[d]), 64'd0);
         check("rst_tap_ready", 64'(tap_ready[d]), 64'd1);
         check("rst_sample_ready", 64'(sample_ready[d]), 64'd1);
         check("rst_result_data", 64'(result_data[d]), 64'd0);
         check("rst_result_ch", 64'(result_ch[d]), 64'd0);
      end

      // Impulse response walks the taps 1..8
      for (int i = 0; i < 8; i++) send_tap(1'b0, 1'b0, 16'(i + 1));
      for (int i = 0; i < 8; i++) send_sample(1'b0, 1'b0, (i == 0) ? 16'd1 : 16'd0, 16'(i + 1));
      wait_drain();

      // Ninth tap write wraps onto tap[0]
      reset_dut(1);
      for (int i = 1; i <= 9; i++) send_tap(1'b0, 1'b0, 16'(i));
      send_sample(1'b0, 1'b0, 16'd1, 16'd9);
      send_sample(1'b0, 1'b0, 16'd0, 16'd2);
      wait_drain();

      // Backpressure: taps 9,2..8, history 1,0 -> next zero sample gives tap[2]=3
      result_ready = 1'b0;
      send_sample(1'b0, 1'b0, 16'd0, 16'd3);
      n = 0;
      while (result_valid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("bp_valid_rise");
      sample_valid = 1'b1; sample_ch = 1'b0; sample_data = 16'd5;
      repeat (5) begin
         @(negedge clk);
         check("bp_result_valid", 64'(result_valid[0]), 64'd1);
         check("bp_result_data", 64'(result_data[0]), 64'd3);
         check("bp_sample_ready", 64'(sample_ready[0]), 64'd0);
      end
      result_ready = 1'b1;
      // history 5,0,0,1 against taps 9,2,3,4 -> 45 + 4
      finish_sample(1'b1, 16'd49);
      wait_drain();

      // Channel isolation
      reset_dut(1);
      for (int i = 0; i < 8; i++) send_tap(1'b0, 1'b0, 16'(i + 1));
      for (int i = 0; i < 8; i++) send_tap(1'b0, 1'b1, 16'd2);
      send_sample(1'b0, 1'b1, 16'd3, 16'd6);
      send_sample(1'b0, 1'b0, 16'd1, 16'd1);
      send_sample(1'b0, 1'b0, 16'd0, 16'd2);
      wait_drain();

      // Simultaneous tap and sample: tap[0]=100 is used; history 1,0,1 -> 100 + 3
      sel = 1'b0;
      n = 0;
      while (sample_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("both_idle");
      tap_valid = 1'b1; tap_ch = 1'b0; tap_data = 16'd100;
      sample_valid = 1'b1; sample_ch = 1'b0; sample_data = 16'd1;
      check("both_tap_ready", 64'(tap_ready[0]), 64'd1);
      check("both_sample_ready", 64'(sample_ready[0]), 64'd1);
      q.push_back('{dut: 0, ch: 0, data: 16'd103, acc_cyc: cyc});
      @(negedge clk);
      tap_valid = 1'b0; sample_valid = 1'b0;
      wait_drain();

      // Scaling on the OUT_SHIFT=15 engine
      for (int i = 0; i < 8; i++) send_tap(1'b1, 1'b0, 16'h7FFF);
      for (int j = 1; j <= 8; j++) send_sample(1'b1, 1'b0, 16'h7FFF, sat_model(j));
      wait_drain();

      // Reset in the third MAC cycle drops the computation and clears the taps
      send_sample(1'b0, 1'b0, 16'd1, 16'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midmac_result_valid", 64'(result_valid[0]), 64'd0);
      check("midmac_sample_ready", 64'(sample_ready[0]), 64'd1);
      check("midmac_tap_ready", 64'(tap_ready[0]), 64'd1);
      repeat (12) @(negedge clk);
      send_sample(1'b0, 1'b0, 16'd1, 16'd0);
      wait_drain();

      check("queue_empty", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
